// File: rtl/axis_size_check_slice.sv
// 512-bit AXI-Stream register slice: two-entry skid buffer, packet framing and tuser size check.
// Build macro SIZE_CHECK_CNT_SAT_EN: statistics counters saturate at all-ones instead of wrapping.
module axis_size_check_slice #(
    parameter  int unsigned CNT_W      = 32,
    parameter  int unsigned BYTE_CNT_W = 48,
    localparam int unsigned DATA_W     = 512,
    localparam int unsigned KEEP_W     = 64,
    localparam int unsigned USER_W     = 48
) (
    input  logic                  axis_aclk,
    input  logic                  mod_rstn,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [KEEP_W-1:0]     s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic [USER_W-1:0]     s_axis_tuser,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [KEEP_W-1:0]     m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [USER_W-1:0]     m_axis_tuser,
    input  logic                  m_axis_tready,
    input  logic                  stats_clr,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [BYTE_CNT_W-1:0] byte_cnt,
    output logic [CNT_W-1:0]      size_err_cnt,
    output logic                  size_err
);

    localparam int unsigned SIZE_W = 16;
    localparam int unsigned BCNT_W = 7;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic [USER_W-1:0] user;
    } beat_t;

    typedef enum logic {ST_FIRST = 1'b0, ST_BODY = 1'b1} state_t;

    function automatic logic [BCNT_W-1:0] popcount(input logic [KEEP_W-1:0] k);
        logic [BCNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < KEEP_W; i++) c = c + BCNT_W'(k[i]);
        return c;
    endfunction

    beat_t                 in_beat, main_q, main_d, skid_q, skid_d;
    logic                  m_valid_q, m_valid_d, skid_valid_q, skid_valid_d;
    logic                  s_tready_q, s_tready_d;
    state_t                state_q, state_d;
    logic [SIZE_W-1:0]     acc_q, acc_d, size_ref_q, size_ref_d;
    logic                  acc_ovf_q, acc_ovf_d;
    logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  size_err_q, size_err_d;

    logic                  accept, main_free, eval, mismatch, ovf_base, acc_ovf_cur;
    logic [BCNT_W-1:0]     beat_bytes, byte_inc;
    logic [SIZE_W:0]       acc_sum;
    logic [SIZE_W-1:0]     acc_cur, size_ref_cur;
    logic [CNT_W-1:0]      pkt_base, err_base;
    logic [BYTE_CNT_W-1:0] byte_base;
`ifdef SIZE_CHECK_CNT_SAT_EN
    logic [CNT_W:0]        pkt_sum, err_sum;
    logic [BYTE_CNT_W:0]   byte_sum;
`endif

    // Skid buffer: main feeds the output, skid absorbs the one beat in flight when ready drops.
    always_comb begin
        in_beat.data = s_axis_tdata;
        in_beat.keep = s_axis_tkeep;
        in_beat.last = s_axis_tlast;
        in_beat.user = s_axis_tuser;
        accept       = s_axis_tvalid && s_tready_q;
        main_free    = !m_valid_q || m_axis_tready;
        main_d       = main_q;
        m_valid_d    = m_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (main_free) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                m_valid_d    = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d    = in_beat;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
        s_tready_d = !skid_valid_d;
    end

    // Framing and size check; the overflow flag makes any packet above 65535 bytes a mismatch.
    always_comb begin
        beat_bytes = popcount(s_axis_tkeep);
        state_d    = state_q;
        acc_d      = acc_q;
        acc_ovf_d  = acc_ovf_q;
        size_ref_d = size_ref_q;
        eval       = 1'b0;
        if (state_q == ST_FIRST) begin
            acc_sum      = (SIZE_W+1)'(beat_bytes);
            ovf_base     = 1'b0;
            size_ref_cur = s_axis_tuser[SIZE_W-1:0];
        end else begin
            acc_sum      = {1'b0, acc_q} + (SIZE_W+1)'(beat_bytes);
            ovf_base     = acc_ovf_q;
            size_ref_cur = size_ref_q;
        end
        acc_ovf_cur = ovf_base || acc_sum[SIZE_W];
        acc_cur     = acc_sum[SIZE_W] ? '1 : acc_sum[SIZE_W-1:0];
        mismatch    = acc_ovf_cur || (acc_cur != size_ref_cur) || (size_ref_cur == '0);
        if (accept) begin
            acc_d      = acc_cur;
            acc_ovf_d  = acc_ovf_cur;
            size_ref_d = size_ref_cur;
            eval       = s_axis_tlast;
            state_d    = s_axis_tlast ? ST_FIRST : ST_BODY;
        end
    end

    // Statistics: a clear zeroes the base, any same-cycle increment lands on top of it.
    always_comb begin
        pkt_base   = stats_clr ? '0 : pkt_cnt_q;
        err_base   = stats_clr ? '0 : err_cnt_q;
        byte_base  = stats_clr ? '0 : byte_cnt_q;
        byte_inc   = accept ? beat_bytes : '0;
        size_err_d = eval && mismatch;
`ifdef SIZE_CHECK_CNT_SAT_EN
        pkt_sum    = {1'b0, pkt_base} + (CNT_W+1)'(eval);
        err_sum    = {1'b0, err_base} + (CNT_W+1)'(size_err_d);
        byte_sum   = {1'b0, byte_base} + (BYTE_CNT_W+1)'(byte_inc);
        pkt_cnt_d  = pkt_sum[CNT_W] ? '1 : pkt_sum[CNT_W-1:0];
        err_cnt_d  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        byte_cnt_d = byte_sum[BYTE_CNT_W] ? '1 : byte_sum[BYTE_CNT_W-1:0];
`else
        pkt_cnt_d  = pkt_base + CNT_W'(eval);
        err_cnt_d  = err_base + CNT_W'(size_err_d);
        byte_cnt_d = byte_base + BYTE_CNT_W'(byte_inc);
`endif
    end

    always_ff @(posedge axis_aclk) begin
        if (!mod_rstn) begin
            m_valid_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            s_tready_q   <= 1'b0;
            state_q      <= ST_FIRST;
            acc_q        <= '0;
            acc_ovf_q    <= 1'b0;
            size_ref_q   <= '0;
            pkt_cnt_q    <= '0;
            err_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            size_err_q   <= 1'b0;
        end else begin
            m_valid_q    <= m_valid_d;
            skid_valid_q <= skid_valid_d;
            s_tready_q   <= s_tready_d;
            state_q      <= state_d;
            acc_q        <= acc_d;
            acc_ovf_q    <= acc_ovf_d;
            size_ref_q   <= size_ref_d;
            pkt_cnt_q    <= pkt_cnt_d;
            err_cnt_q    <= err_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            size_err_q   <= size_err_d;
        end
    end

    // Payload registers carry no reset; their contents only matter while the matching valid is set.
    always_ff @(posedge axis_aclk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign s_axis_tready = s_tready_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = main_q.data;
    assign m_axis_tkeep  = main_q.keep;
    assign m_axis_tlast  = main_q.last;
    assign m_axis_tuser  = main_q.user;
    assign pkt_cnt       = pkt_cnt_q;
    assign byte_cnt      = byte_cnt_q;
    assign size_err_cnt  = err_cnt_q;
    assign size_err      = size_err_q;

endmodule

// File: tb/tb_axis_size_check_slice.sv
// Self-checking bench for axis_size_check_slice: queue-based reference model plus directed and random traffic.
module tb_axis_size_check_slice;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn = 1'b0;
    logic         s_tvalid = 1'b0;
    logic [511:0] s_tdata = '0;
    logic [63:0]  s_tkeep = '0;
    logic         s_tlast = 1'b0;
    logic [47:0]  s_tuser = '0;
    logic         m_tready = 1'b1;
    logic         stats_clr = 1'b0;

    logic         s_tready, m_tvalid, m_tlast, size_err;
    logic [511:0] m_tdata;
    logic [63:0]  m_tkeep;
    logic [47:0]  m_tuser;
    logic [31:0]  pkt_cnt, err_cnt;
    logic [47:0]  byte_cnt;

    logic         sm_s_tready, sm_m_tvalid, sm_m_tlast, sm_size_err;
    logic [511:0] sm_m_tdata;
    logic [63:0]  sm_m_tkeep;
    logic [47:0]  sm_m_tuser;
    logic [3:0]   sm_pkt_cnt, sm_err_cnt;
    logic [7:0]   sm_byte_cnt;

    axis_size_check_slice dut (
        .axis_aclk(clk), .mod_rstn(rstn),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .stats_clr(stats_clr), .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt),
        .size_err_cnt(err_cnt), .size_err(size_err)
    );

    axis_size_check_slice #(.CNT_W(4), .BYTE_CNT_W(8)) dut_small (
        .axis_aclk(clk), .mod_rstn(rstn),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(sm_s_tready),
        .m_axis_tvalid(sm_m_tvalid), .m_axis_tdata(sm_m_tdata), .m_axis_tkeep(sm_m_tkeep),
        .m_axis_tlast(sm_m_tlast), .m_axis_tuser(sm_m_tuser), .m_axis_tready(m_tready),
        .stats_clr(stats_clr), .pkt_cnt(sm_pkt_cnt), .byte_cnt(sm_byte_cnt),
        .size_err_cnt(sm_err_cnt), .size_err(sm_size_err)
    );

    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic [47:0]  u;
    } beat_t;

    // Reference model state: beats held in the slice, counts since last clear, open-packet tally.
    beat_t   mq[$];
    beat_t   mb;
    bit      exp_tready = 1'b0;
    bit      exp_err = 1'b0;
    bit      m_in_pkt = 1'b0;
    bit      mdl_acc, mdl_pop;
    longint  m_pkts = 0, m_bytes = 0, m_errs = 0;
    int      m_sum = 0, m_ref = 0, nb;
    int      n_accepted = 0, n_popped = 0;

    int      n_checks = 0, n_fail = 0, err_pulses = 0;
    bit      rand_mready = 1'b0;

    function automatic longint proj(input longint v, input int w);
        longint lim;
        lim = longint'(1) << w;
`ifdef SIZE_CHECK_CNT_SAT_EN
        return (v >= lim) ? lim - 1 : v;
`else
        return v % lim;
`endif
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            mq.delete();
            exp_tready = 1'b0;
            exp_err    = 1'b0;
            m_in_pkt   = 1'b0;
            m_pkts     = 0;
            m_bytes    = 0;
            m_errs     = 0;
        end else begin
            mdl_acc = s_tvalid && exp_tready;
            mdl_pop = (mq.size() > 0) && m_tready;
            exp_err = 1'b0;
            if (stats_clr) begin
                m_pkts  = 0;
                m_bytes = 0;
                m_errs  = 0;
            end
            if (mdl_pop) begin
                void'(mq.pop_front());
                n_popped++;
            end
            if (mdl_acc) begin
                nb = $countones(s_tkeep);
                m_bytes += nb;
                n_accepted++;
                mb.d = s_tdata; mb.k = s_tkeep; mb.l = s_tlast; mb.u = s_tuser;
                mq.push_back(mb);
                if (!m_in_pkt) begin
                    m_ref = int'(s_tuser[15:0]);
                    m_sum = nb;
                end else begin
                    m_sum += nb;
                end
                if (s_tlast) begin
                    m_pkts++;
                    if (m_sum != m_ref || m_ref == 0) begin
                        m_errs++;
                        exp_err = 1'b1;
                    end
                end
                m_in_pkt = !s_tlast;
            end
            exp_tready = mq.size() < 2;
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cycle();
        chk("s_tready", 512'(s_tready), 512'(exp_tready));
        chk("m_tvalid", 512'(m_tvalid), 512'(mq.size() > 0));
        chk("sm_s_tready", 512'(sm_s_tready), 512'(exp_tready));
        if (mq.size() > 0) begin
            chk("m_tdata", m_tdata, mq[0].d);
            chk("m_tkeep", 512'(m_tkeep), 512'(mq[0].k));
            chk("m_tlast", 512'(m_tlast), 512'(mq[0].l));
            chk("m_tuser", 512'(m_tuser), 512'(mq[0].u));
        end
        chk("size_err", 512'(size_err), 512'(exp_err));
        chk("pkt_cnt", 512'(pkt_cnt), 512'(proj(m_pkts, 32)));
        chk("byte_cnt", 512'(byte_cnt), 512'(proj(m_bytes, 48)));
        chk("size_err_cnt", 512'(err_cnt), 512'(proj(m_errs, 32)));
        chk("sm_pkt_cnt", 512'(sm_pkt_cnt), 512'(proj(m_pkts, 4)));
        chk("sm_byte_cnt", 512'(sm_byte_cnt), 512'(proj(m_bytes, 8)));
        chk("sm_err_cnt", 512'(sm_err_cnt), 512'(proj(m_errs, 4)));
        if (size_err === 1'b1) err_pulses++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        if (rand_mready) m_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                             input logic [47:0] u);
        bit go, done;
        done = 1'b0;
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u;
        for (int i = 0; i < 200; i++) begin
            go = exp_tready;
            tick();
            if (go) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
        s_tvalid = 1'b0;
    endtask

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic send_pkt(input int nbeats, input int mode);
        logic [63:0] keeps[4];
        int          total, size;
        logic [47:0] u;
        total = 0;
        for (int i = 0; i < nbeats; i++) begin
            keeps[i] = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : '1;
            total += $countones(keeps[i]);
        end
        case (mode)
            0:       size = total;
            1:       size = total + int'($urandom_range(1, 5));
            2:       size = (total > 0) ? total - 1 : 7;
            default: size = 0;
        endcase
        for (int i = 0; i < nbeats; i++) begin
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                stats_clr = ($urandom_range(0, 19) == 0);
                tick();
                stats_clr = 1'b0;
            end
            if (i == 0) u = {16'($urandom), 16'($urandom), 16'(size)};
            else        u = 48'({$urandom, $urandom});
            send_beat(rand_data(), keeps[i], i == nbeats - 1, u);
        end
    endtask

    task automatic pulse_clr();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
    endtask

    logic [511:0] d0;
    beat_t        bp[4];
    int           idx, n0, p0;
    bit           go;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_tready", 512'(s_tready), 512'(0));
        chk("rst_mvalid", 512'(m_tvalid), 512'(0));
        chk("rst_pkt_cnt", 512'(pkt_cnt), 512'(0));
        rstn = 1'b1;
        tick();
        chk("tready_after_rst", 512'(s_tready), 512'(1));

        // Single-beat packet, size matches
        m_tready = 1'b1;
        d0 = rand_data();
        send_beat(d0, '1, 1'b1, {16'h0002, 16'h0001, 16'd64});
        chk("single_out_valid", 512'(m_tvalid), 512'(1));
        chk("single_out_data", m_tdata, d0);
        chk("single_pkt_cnt", 512'(pkt_cnt), 512'(1));
        chk("single_byte_cnt", 512'(byte_cnt), 512'(64));
        chk("single_model_err", 512'(m_errs), 512'(0));
        tick();

        // Three-beat packet, 144 bytes against size 150
        pulse_clr();
        err_pulses = 0;
        send_beat(rand_data(), '1, 1'b0, {16'h0003, 16'h0004, 16'd150});
        send_beat(rand_data(), '1, 1'b0, 48'h0);
        send_beat(rand_data(), 64'hFFFF, 1'b1, 48'h0);
        repeat (3) tick();
        chk("mis_err_pulses", 512'(err_pulses), 512'(1));
        chk("mis_err_cnt", 512'(err_cnt), 512'(1));
        chk("mis_pkt_cnt", 512'(pkt_cnt), 512'(1));
        chk("mis_byte_cnt", 512'(byte_cnt), 512'(144));

        // Backpressure: four beats offered while the output is stalled
        n0 = n_accepted;
        p0 = n_popped;
        for (int i = 0; i < 4; i++) begin
            bp[i].d = rand_data(); bp[i].k = '1; bp[i].l = (i == 3);
            bp[i].u = (i == 0) ? {32'h0, 16'd256} : 48'h0;
        end
        m_tready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            s_tvalid = 1'b1; s_tdata = bp[idx].d; s_tkeep = bp[idx].k;
            s_tlast = bp[idx].l; s_tuser = bp[idx].u;
            go = exp_tready;
            tick();
            if (go && idx < 3) idx++;
        end
        chk("bp_accepted", 512'(n_accepted - n0), 512'(2));
        chk("bp_tready_low", 512'(s_tready), 512'(0));
        m_tready = 1'b1;
        idx = n_accepted - n0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            s_tvalid = 1'b1; s_tdata = bp[idx].d; s_tkeep = bp[idx].k;
            s_tlast = bp[idx].l; s_tuser = bp[idx].u;
            go = exp_tready;
            tick();
            if (go) idx++;
        end
        s_tvalid = 1'b0;
        repeat (4) tick();
        chk("bp_all_sent", 512'(idx), 512'(4));
        chk("bp_popped", 512'(n_popped - p0), 512'(4));

        // Reset in the middle of a four-beat packet
        send_beat(rand_data(), '1, 1'b0, {32'h0, 16'd256});
        send_beat(rand_data(), '1, 1'b0, 48'h0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midrst_mvalid", 512'(m_tvalid), 512'(0));
        chk("midrst_pkt_cnt", 512'(pkt_cnt), 512'(0));
        send_beat(rand_data(), '1, 1'b1, {32'h0, 16'd64});
        tick();
        chk("midrst_new_pkt_cnt", 512'(pkt_cnt), 512'(1));
        chk("midrst_new_err_cnt", 512'(err_cnt), 512'(0));

        // Clear in the same cycle as a tlast evaluation
        send_beat(rand_data(), '1, 1'b1, {32'h0, 16'd64});
        for (int c = 0; c < 20 && !exp_tready; c++) tick();
        s_tvalid = 1'b1; s_tdata = rand_data(); s_tkeep = '1; s_tlast = 1'b1;
        s_tuser = {32'h0, 16'd64};
        stats_clr = 1'b1;
        go = exp_tready;
        tick();
        stats_clr = 1'b0;
        s_tvalid = 1'b0;
        chk("clr_accept", 512'(go), 512'(1));
        chk("clr_pkt_cnt", 512'(pkt_cnt), 512'(1));

        // Seventeen packets through the 4-bit counter instance
        pulse_clr();
        for (int i = 0; i < 17; i++) send_beat(rand_data(), '1, 1'b1, {32'h0, 16'd64});
        tick();
        chk("sat_pkt_cnt_wide", 512'(pkt_cnt), 512'(17));
`ifdef SIZE_CHECK_CNT_SAT_EN
        chk("sat_pkt_cnt_small", 512'(sm_pkt_cnt), 512'(15));
`else
        chk("sat_pkt_cnt_small", 512'(sm_pkt_cnt), 512'(1));
`endif

        // 65536-byte packet must flag; exactly 65535 bytes must not
        pulse_clr();
        for (int i = 0; i < 1024; i++)
            send_beat(rand_data(), '1, i == 1023, (i == 0) ? {32'h0, 16'hFFFF} : 48'h0);
        for (int i = 0; i < 1024; i++)
            send_beat(rand_data(), (i == 1023) ? 64'h7FFF_FFFF_FFFF_FFFF : '1, i == 1023,
                      (i == 0) ? {32'h0, 16'hFFFF} : 48'h0);
        repeat (2) tick();
        chk("long_err_cnt", 512'(err_cnt), 512'(1));
        chk("long_pkt_cnt", 512'(pkt_cnt), 512'(2));

        // Random traffic with random backpressure and occasional clears
        rand_mready = 1'b1;
        for (int p = 0; p < 150; p++) send_pkt(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
        rand_mready = 1'b0;
        m_tready = 1'b1;
        repeat (5) tick();
        chk("final_drained", 512'(mq.size()), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

endmodule

// File: doc/axis_size_check_slice.md
# axis_size_check_slice

Single-port 512-bit AXI-Stream register slice that sits directly upstream of each stream-switch input (QDMA H2C and adapter RX), one instance per port. It fully registers the data path and the ready path with a two-entry skid buffer, tracks packet framing, and checks the byte count carried in `tuser[15:0]` against the bytes actually delivered. It exposes packet, byte and size-error counters for the port's register block.

## Interface

**Parameters**

- `CNT_W`, default 32: width of the packet and error counters.
- `BYTE_CNT_W`, default 48: width of the byte counter.

**Ports**

- `axis_aclk`, in, 1: the only clock.
- `mod_rstn`, in, 1: reset, synchronous and active-low.
- `s_axis_tvalid`, in, 1: upstream beat valid.
- `s_axis_tdata`, in, 512: upstream data.
- `s_axis_tkeep`, in, 64: upstream byte enables.
- `s_axis_tlast`, in, 1: upstream end of packet.
- `s_axis_tuser`, in, 48: {dst[47:32], src[31:16], size[15:0]}.
- `s_axis_tready`, out, 1: registered ready to upstream.
- `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast`, `m_axis_tuser`, out, 1/512/64/1/48: to the stream switch.
- `m_axis_tready`, in, 1: ready from the stream switch.
- `stats_clr`, in, 1: single-cycle pulse that clears all counters.
- `pkt_cnt`, out, CNT_W: packets accepted on the input side.
- `byte_cnt`, out, BYTE_CNT_W: bytes accepted (sum of `popcount(tkeep)`).
- `size_err_cnt`, out, CNT_W: packets whose delivered length differs from `tuser.size`.
- `size_err`, out, 1: one-cycle pulse per mismatching packet.

## Operation

- **Skid buffer.** Main register plus skid register.
  - `s_axis_tready` = !skid_valid, taken from a register.
  - A beat accepted while the main register is occupied and `m_axis_tready` is 0 goes to skid.
  - When the main register drains, skid moves into main.
  - Data, tkeep, tlast and tuser pass through unmodified and in order. No beat is ever dropped or duplicated.
- **Framing FSM**, input side, advances on an accepted beat only.
  - FIRST: capture `size_ref = tuser[15:0]`; `acc = popcount(tkeep)`. If tlast is set, evaluate immediately and stay in FIRST; otherwise go to BODY.
  - BODY: `acc += popcount(tkeep)`. On tlast, evaluate and return to FIRST.
- **Accumulator.** 16-bit and saturating at 0xFFFF, so packets longer than 65535 bytes always flag an error.
- **Evaluate.** Error when `acc_total != size_ref` or `size_ref == 0`.
  - On error: `size_err` pulses and `size_err_cnt` increments.
  - Every evaluation increments `pkt_cnt`.
  - `byte_cnt` adds `popcount(tkeep)` on every accepted beat.
- **`tuser` checking.** `tuser` on non-first beats is forwarded but not checked.
- **`stats_clr`.** Zeroes all three counters. An increment in the same cycle is applied on top of zero, so the result is 0 or the new increment. The framing FSM and the accumulator are not affected.

## Timing

- **Reset values** (held while `mod_rstn` = 0):
  - `s_axis_tready` = 0, `m_axis_tvalid` = 0, `size_err` = 0.
  - All counters 0, FSM in FIRST, skid empty.
  - Data outputs are don't-care.
- `s_axis_tready` rises in the first cycle after `mod_rstn` is sampled high.
- **Latency.** One cycle from input acceptance to `m_axis_tvalid` when the slice is empty.
- **Throughput.** Full rate, one beat per cycle, with `m_axis_tready` held at 1.
- **Output handshake.**
  - `m_axis_tvalid` never deasserts, and its payload never changes, until `m_axis_tready` is 1.
  - `m_axis_tvalid` has no combinational dependence on `m_axis_tready`.
- **`s_axis_tready` deassertion.** It drops one cycle after the skid register fills, and at most one beat is absorbed in that window.
- **Counter timing.** Counters and `size_err` update in the cycle after the tlast beat is accepted on the input, independent of output backpressure.
- **Reset mid-packet.** Buffered beats are discarded, the partial packet is not counted, and the FSM returns to FIRST.

## Configuration

- **`SIZE_CHECK_CNT_SAT_EN` defined:** `pkt_cnt`, `byte_cnt` and `size_err_cnt` saturate at all-ones.
- **`SIZE_CHECK_CNT_SAT_EN` undefined:** the counters wrap modulo 2^width.
- `size_err` pulses identically in both builds.

## Test plan

- **Single-beat packet.** tuser.size=64, tkeep all-ones, tlast=1, `m_axis_tready`=1 → output beat one cycle later, identical payload; `pkt_cnt`=1, `byte_cnt`=64, no `size_err`.
- **Three-beat mismatch.** tuser.size=150; tkeep 64/64/16 bytes (total 144) → `size_err` pulses once, `size_err_cnt`=1, `pkt_cnt`=1, all three beats forwarded.
- **Backpressure.** Hold `m_axis_tready`=0 while sending 4 beats → at most 2 beats accepted, `s_axis_tready`=0; release → beats emerge in order, none lost.
- **Reset mid-packet.** Drop `mod_rstn` for 1 cycle after beat 2 of a 4-beat packet → `m_axis_tvalid`=0, counters 0; a new 1-beat packet afterwards checks clean.
- **Clear collision.** `stats_clr` in the same cycle as a tlast evaluation → `pkt_cnt`=1 afterwards.
- **Saturation.** Preload `pkt_cnt` near max via a 4-bit `CNT_W` build; send 17 packets → with the macro defined `pkt_cnt`=15, without it `pkt_cnt`=1.
